ramb_burst_ctrl: RTL and testbench
==================================

// Module: ramb_burst_ctrl
// PURPOSE
//  Burst command sequencer feeding port B of the dual-port RAM (clk_b side).
//  Accepts one burst command at a time, streams write beats into RAM or issues
//  reads and returns RAM data on a back-pressured stream. Handles RAM read
//  latency with a credit-controlled return FIFO. Single clock domain.
// PARAMETERS
//  DW      16  data width; equals the RAM port-B data width
//  AW      4   address width; equals the RAM port-B address width
//  LW      4   command length width; a burst has i_cmd_len+1 beats (1..2^LW)
//  RD_LAT  1   RAM read latency in clk_b cycles from addr/rd to data valid (>=1)
// PORTS
//  clk_b         in   1    clock
//  rst_b         in   1    asynchronous reset, active high
//  i_cmd_valid   in   1    command valid
//  o_cmd_ready   out  1    command ready; high only in IDLE
//  i_cmd_wr      in   1    1 = write burst, 0 = read burst
//  i_cmd_addr    in   AW   start address
//  i_cmd_len     in   LW   beats minus 1
//  i_wdata_valid in   1    write beat valid
//  o_wdata_ready out  1    write beat ready
//  i_wdata       in   DW   write beat data
//  o_rdata_valid out  1    read beat valid (FIFO not empty)
//  i_rdata_ready in   1    read beat ready
//  o_rdata       out  DW   read beat data (FIFO head)
//  o_done        out  1    one-cycle pulse at burst completion
//  o_cmd_err     out  1    one-cycle pulse on rejected command (0 without macro)
//  o_ram_data    out  DW   to RAM i_data_b, registered
//  o_ram_addr    out  AW   to RAM i_addr_b, registered
//  o_ram_wr_en   out  1    to RAM i_wr_en_b, registered
//  i_ram_data    in   DW   from RAM o_data_b
// BEHAVIOUR
//  Reset: FSM=IDLE; o_ram_wr_en=0, o_ram_addr=0, o_ram_data=0, o_done=0,
//   o_cmd_err=0, o_rdata_valid=0, FIFO empty, all counters 0, in-flight pipe cleared.
//  Handshake: transfer when valid&&ready in the same cycle. Valids never depend on readies.
//  FSM IDLE -> WR (cmd accepted, i_cmd_wr=1) | RD (cmd accepted, i_cmd_wr=0).
//   Accept latches addr into addr_cnt and len into beat_cnt.
//  WR: o_wdata_ready=1. Each accepted beat: next cycle o_ram_wr_en=1,
//   o_ram_addr=addr_cnt, o_ram_data=i_wdata; addr_cnt+1; beat_cnt-1.
//   No accepted beat -> o_ram_wr_en=0 next cycle (gaps allowed).
//   Last beat accepted -> IDLE; o_done pulses the cycle its RAM write is driven.
//  RD: issues one read per cycle while credit>0 and beats remain: next cycle
//   o_ram_wr_en=0, o_ram_addr=addr_cnt; tag 1 enters RD_LAT-deep valid pipe.
//   i_ram_data pushed into return FIFO when the pipe output tag is 1.
//  Return FIFO depth RD_LAT+2; credit = depth - fifo_count - tags in flight;
//   the FIFO never overflows and no RAM data is dropped.
//  RD -> DRAIN after last issue; DRAIN -> IDLE when pipe empty and FIFO empty.
//   o_done pulses the cycle of the last o_rdata handshake.
//  Simultaneous FIFO push and pop: count unchanged, both complete.
//  FIFO full: no issue that cycle; empty: o_rdata_valid=0; o_rdata=X don't-care.
//  Address arithmetic mod 2^AW (wraps 2^AW-1 -> 0). Beat counter never underflows.
//  o_ram_wr_en is 0 in IDLE, RD, and DRAIN. Write bursts and read bursts never overlap.
//  Reset mid-burst: burst abandoned, FIFO and pipe flushed, no o_done.
// CONFIGURATION
//  RAMB_BURST_ADDR_CHK_EN defined: a command with addr+len > 2^AW-1 is consumed
//   (cmd handshake completes) but not executed; o_cmd_err pulses next cycle;
//   FSM stays IDLE; no RAM access; no o_done.
//  Not defined: o_cmd_err tied 0; bursts wrap address mod 2^AW.
// TESTING
//  Write len=3 addr=4, data A0..A3 with no gaps -> RAM writes at 4,5,6,7; o_done with the last write.
//  Read len=3 addr=4, i_rdata_ready=1 -> o_rdata A0..A3 in order; o_done on the 4th handshake.
//  Read len=15, i_rdata_ready low for 10 cycles -> issues stall at RD_LAT+2 outstanding; no loss; all 16 beats in order.
//  Write addr=14 len=3 -> no macro: writes 14,15,0,1; macro: o_cmd_err=1, no o_ram_wr_en, o_cmd_ready stays 1.
//  rst_b asserted during the 2nd beat of a read of len=7 -> all outputs at reset values; next command executes normally.
//  Write beats with valid toggling 1,0,1,0 -> o_ram_wr_en mirrors the gaps one cycle later; address advances only on beats.

Source files
------------

// File: rtl/ramb_burst_ctrl.sv
// Burst command sequencer for RAM port B: streams write beats, issues reads and
// returns data through a credit-controlled FIFO. Optional macro RAMB_BURST_ADDR_CHK_EN.
module ramb_burst_ctrl #(
   parameter int DW     = 16,
   parameter int AW     = 4,
   parameter int LW     = 4,
   parameter int RD_LAT = 1
) (
   input  logic          clk_b,
   input  logic          rst_b,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic          i_cmd_wr,
   input  logic [AW-1:0] i_cmd_addr,
   input  logic [LW-1:0] i_cmd_len,
   input  logic          i_wdata_valid,
   output logic          o_wdata_ready,
   input  logic [DW-1:0] i_wdata,
   output logic          o_rdata_valid,
   input  logic          i_rdata_ready,
   output logic [DW-1:0] o_rdata,
   output logic          o_done,
   output logic          o_cmd_err,
   output logic [DW-1:0] o_ram_data,
   output logic [AW-1:0] o_ram_addr,
   output logic          o_ram_wr_en,
   input  logic [DW-1:0] i_ram_data
);

   localparam int DEPTH = RD_LAT + 2;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int PW    = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

   state_t        state;
   logic [AW-1:0] addr_cnt;
   logic [LW-1:0] beat_cnt;
   logic          wr_done_q;
   logic          rd_q;
   logic [RD_LAT-1:0] tag_pipe;
   logic [DW-1:0] fifo_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] fifo_cnt;
   logic [CW-1:0] inflight;
   logic          credit_ok;
   logic          cmd_acc;
   logic          cmd_bad;
   logic          wr_beat;
   logic          issue;
   logic          push;
   logic          pop;
   logic          rd_last;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_cmd_ready   = (state == IDLE);
   assign o_wdata_ready = (state == WR);
   assign o_rdata_valid = (fifo_cnt != '0);
   assign o_rdata       = fifo_mem[rd_ptr];

   assign cmd_acc = i_cmd_valid && (state == IDLE);
   assign wr_beat = i_wdata_valid && (state == WR);
   assign push    = tag_pipe[RD_LAT-1];
   assign pop     = o_rdata_valid && i_rdata_ready;

   // Credit counts both the issue register and the latency pipe as in flight
   always_comb begin
      inflight = CW'(rd_q);
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         inflight = inflight + CW'(tag_pipe[i]);
      end
   end

   assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
   assign issue     = (state == RD) && credit_ok;
   assign rd_last   = (state == DRAIN) && pop && (fifo_cnt == CW'(1)) && (inflight == '0);
   assign o_done    = wr_done_q | rd_last;

`ifdef RAMB_BURST_ADDR_CHK_EN
   localparam int SW = AW + LW + 1;
   logic err_q;

   assign cmd_bad   = (SW'(i_cmd_addr) + SW'(i_cmd_len)) > SW'((1 << AW) - 1);
   assign o_cmd_err = err_q;

   always_ff @(posedge clk_b or posedge rst_b) begin
      if (rst_b) err_q <= 1'b0;
      else       err_q <= cmd_acc && cmd_bad;
   end
`else
   assign cmd_bad   = 1'b0;
   assign o_cmd_err = 1'b0;
`endif

   always_ff @(posedge clk_b or posedge rst_b) begin
      if (rst_b) begin
         state       <= IDLE;
         addr_cnt    <= '0;
         beat_cnt    <= '0;
         wr_done_q   <= 1'b0;
         o_ram_wr_en <= 1'b0;
         o_ram_addr  <= '0;
         o_ram_data  <= '0;
      end else begin
         wr_done_q <= 1'b0;
         case (state)
            IDLE: begin
               o_ram_wr_en <= 1'b0;
               if (cmd_acc && !cmd_bad) begin
                  addr_cnt <= i_cmd_addr;
                  beat_cnt <= i_cmd_len;
                  state    <= i_cmd_wr ? WR : RD;
               end
            end
            WR: begin
               o_ram_wr_en <= wr_beat;
               if (wr_beat) begin
                  o_ram_addr <= addr_cnt;
                  o_ram_data <= i_wdata;
                  addr_cnt   <= addr_cnt + AW'(1);
                  if (beat_cnt == '0) begin
                     state     <= IDLE;
                     wr_done_q <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt - LW'(1);
                  end
               end
            end
            RD: begin
               o_ram_wr_en <= 1'b0;
               if (issue) begin
                  o_ram_addr <= addr_cnt;
                  addr_cnt   <= addr_cnt + AW'(1);
                  if (beat_cnt == '0) state <= DRAIN;
                  else                beat_cnt <= beat_cnt - LW'(1);
               end
            end
            DRAIN: begin
               o_ram_wr_en <= 1'b0;
               if (rd_last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_b or posedge rst_b) begin
      if (rst_b) begin
         rd_q     <= 1'b0;
         tag_pipe <= '0;
      end else begin
         rd_q        <= issue;
         tag_pipe[0] <= rd_q;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk_b or posedge rst_b) begin
      if (rst_b) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_b) begin
      if (push) fifo_mem[wr_ptr] <= i_ram_data;
   end

endmodule

// File: tb/tb_ramb_burst_ctrl.sv
// Scoreboard bench for ramb_burst_ctrl with a behavioural RAM on port B.
module tb_ramb_burst_ctrl;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int LW = 4;
   localparam int RD_LAT = 1;

   logic          clk_b = 1'b0;
   logic          rst_b = 1'b1;
   logic          i_cmd_valid = 1'b0;
   logic          o_cmd_ready;
   logic          i_cmd_wr = 1'b0;
   logic [AW-1:0] i_cmd_addr = '0;
   logic [LW-1:0] i_cmd_len = '0;
   logic          i_wdata_valid = 1'b0;
   logic          o_wdata_ready;
   logic [DW-1:0] i_wdata = '0;
   logic          o_rdata_valid;
   logic          i_rdata_ready = 1'b1;
   logic [DW-1:0] o_rdata;
   logic          o_done;
   logic          o_cmd_err;
   logic [DW-1:0] o_ram_data;
   logic [AW-1:0] o_ram_addr;
   logic          o_ram_wr_en;
   logic [DW-1:0] i_ram_data;

   int checks = 0;
   int errors = 0;
   int exp_err = 0;

   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic done; } wr_exp_t;
   typedef struct { logic [DW-1:0] data; logic done; } rd_exp_t;
   wr_exp_t wr_q[$];
   rd_exp_t rd_q[$];

   logic [DW-1:0] ram [16];
   logic [DW-1:0] ref_mem [16];

   ramb_burst_ctrl #(.DW(DW), .AW(AW), .LW(LW), .RD_LAT(RD_LAT)) dut (
      .clk_b(clk_b), .rst_b(rst_b),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
      .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
      .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
      .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
      .o_done(o_done), .o_cmd_err(o_cmd_err),
      .o_ram_data(o_ram_data), .o_ram_addr(o_ram_addr), .o_ram_wr_en(o_ram_wr_en),
      .i_ram_data(i_ram_data)
   );

   always #5 clk_b = ~clk_b;

   // Port-B RAM with one cycle of read latency
   always @(posedge clk_b) begin
      if (o_ram_wr_en) ram[o_ram_addr] <= o_ram_data;
      i_ram_data <= ram[o_ram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a RAM write or a read beat
   always @(negedge clk_b) begin
      if (!rst_b) begin
         logic exp_done;
         logic ev;
         exp_done = 1'b0;
         ev = 1'b0;
         if (o_ram_wr_en) begin
            ev = 1'b1;
            if (wr_q.size() == 0) begin
               chk("wr_unexpected", 1, 0);
            end else begin
               wr_exp_t e;
               e = wr_q.pop_front();
               chk("wr_addr", 32'(o_ram_addr), 32'(e.addr));
               chk("wr_data", 32'(o_ram_data), 32'(e.data));
               exp_done = exp_done | e.done;
            end
         end
         if (o_rdata_valid && i_rdata_ready) begin
            ev = 1'b1;
            if (rd_q.size() == 0) begin
               chk("rd_unexpected", 1, 0);
            end else begin
               rd_exp_t r;
               r = rd_q.pop_front();
               chk("rd_data", 32'(o_rdata), 32'(r.data));
               exp_done = exp_done | r.done;
            end
         end
         if (ev || o_done) chk("done", 32'(o_done), 32'(exp_done));
         if (o_cmd_err) begin
            if (exp_err > 0) exp_err--;
            else chk("cmd_err_unexpected", 1, 0);
         end
      end
   end

   task automatic tick;
      @(posedge clk_b);
      #1;
   endtask

   task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
      int n = 0;
      while (!o_cmd_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("cmd_ready_timeout", 0, 1);
      i_cmd_valid = 1'b1;
      i_cmd_wr    = wr;
      i_cmd_addr  = addr;
      i_cmd_len   = len;
      tick();
      i_cmd_valid = 1'b0;
   endtask

   task automatic wr_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [DW-1:0] base, input bit gaps);
      send_cmd(1'b1, addr, len);
      for (int i = 0; i <= int'(len); i++) begin
         wr_exp_t e;
         logic [AW-1:0] a;
         int n = 0;
         a = addr + AW'(i);
         e.addr = a;
         e.data = base + DW'(i);
         e.done = (i == int'(len));
         wr_q.push_back(e);
         ref_mem[a] = e.data;
         while (!o_wdata_ready && n < 20) begin
            tick();
            n++;
         end
         if (n >= 20) chk("wdata_ready_timeout", 0, 1);
         i_wdata_valid = 1'b1;
         i_wdata = e.data;
         tick();
         i_wdata_valid = 1'b0;
         if (gaps) tick();
      end
   endtask

   task automatic rd_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len);
      for (int i = 0; i <= int'(len); i++) begin
         rd_exp_t r;
         logic [AW-1:0] a;
         a = addr + AW'(i);
         r.data = ref_mem[a];
         r.done = (i == int'(len));
         rd_q.push_back(r);
      end
      send_cmd(1'b0, addr, len);
   endtask

   task automatic wait_idle;
      int n = 0;
      while ((wr_q.size() != 0 || rd_q.size() != 0 || !o_cmd_ready) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) chk("drain_timeout", 0, 1);
      tick();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, 32'(o_cmd_ready), 1);
      chk({tag, "_ram_wr_en"}, 32'(o_ram_wr_en), 0);
      chk({tag, "_ram_addr"}, 32'(o_ram_addr), 0);
      chk({tag, "_ram_data"}, 32'(o_ram_data), 0);
      chk({tag, "_done"}, 32'(o_done), 0);
      chk({tag, "_cmd_err"}, 32'(o_cmd_err), 0);
      chk({tag, "_rdata_valid"}, 32'(o_rdata_valid), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         ram[i]     = 16'h5000 + 16'(i);
         ref_mem[i] = 16'h5000 + 16'(i);
      end
      repeat (3) tick();
      chk_reset_vals("reset");
      rst_b = 1'b0;
      tick();

      // Write A0..A3 to 4..7 without gaps
      wr_burst(4'd4, 4'd3, 16'h00A0, 1'b0);
      wait_idle();

      // Read them back with the sink always ready
      i_rdata_ready = 1'b1;
      rd_burst(4'd4, 4'd3);
      wait_idle();

      // Full-length read with the sink stalled: issue stops at 3 outstanding
      i_rdata_ready = 1'b0;
      rd_burst(4'd0, 4'd15);
      repeat (10) tick();
      chk("stall_ram_addr", 32'(o_ram_addr), 2);
      chk("stall_rdata_valid", 32'(o_rdata_valid), 1);
      chk("stall_cmd_ready", 32'(o_cmd_ready), 0);
      i_rdata_ready = 1'b1;
      wait_idle();

      // Burst crossing the top of the address space
`ifdef RAMB_BURST_ADDR_CHK_EN
      exp_err++;
      send_cmd(1'b1, 4'd14, 4'd3);
      chk("addr_err_pulse", 32'(o_cmd_err), 1);
      chk("addr_err_ready", 32'(o_cmd_ready), 1);
      chk("addr_err_wdata_ready", 32'(o_wdata_ready), 0);
      tick();
      chk("addr_err_clear", 32'(o_cmd_err), 0);
      chk("addr_err_exp", 32'(exp_err), 0);
      repeat (3) tick();
`else
      wr_burst(4'd14, 4'd3, 16'h00C0, 1'b0);
      chk("wrap_cmd_err", 32'(o_cmd_err), 0);
      wait_idle();
      rd_burst(4'd14, 4'd3);
      wait_idle();
`endif

      // Write beats with gaps between them
      wr_burst(4'd8, 4'd3, 16'h00B0, 1'b1);
      wait_idle();
      rd_burst(4'd8, 4'd3);
      wait_idle();

      // Reset during the 2nd beat of a read
      rd_burst(4'd0, 4'd7);
      tick();
      tick();
      rst_b = 1'b1;
      #1;
      chk_reset_vals("midreset");
      rd_q.delete();
      tick();
      chk_reset_vals("midreset_hold");
      rst_b = 1'b0;
      tick();
      rd_burst(4'd4, 4'd3);
      wait_idle();

      chk("final_wr_queue", 32'(wr_q.size()), 0);
      chk("final_rd_queue", 32'(rd_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
